// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath:
// bus-source / load-enable bit positions, CON codes, memory FSM states.
package datapath_pkg;

    localparam int OS_HI     = 0;
    localparam int OS_LO     = 1;
    localparam int OS_ZHI    = 2;
    localparam int OS_ZLO    = 3;
    localparam int OS_PC     = 4;
    localparam int OS_MDR    = 5;
    localparam int OS_INPORT = 6;
    localparam int OS_C      = 7;

    localparam int IE_HI  = 0;
    localparam int IE_LO  = 1;
    localparam int IE_Z   = 2;
    localparam int IE_PC  = 3;
    localparam int IE_MDR = 4;
    localparam int IE_MAR = 5;
    localparam int IE_IR  = 6;
    localparam int IE_Y   = 7;
    localparam int IE_CON = 8;

    typedef enum logic [1:0] {
        CC_ZERO  = 2'b00,
        CC_NZERO = 2'b01,
        CC_POS   = 2'b10,
        CC_NEG   = 2'b11
    } con_cond_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_REQ  = 2'b01,
        MS_DONE = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_if_fsm.sv
// MAR/MDR plus request/ack handshake with timeout.
// Address and write data are frozen while a request is outstanding.
module mem_if_fsm
    import datapath_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MEM_TMO = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              mar_ld,
    input  logic              mdr_ld,
    input  logic [DATA_W-1:0] bus_d,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam logic [7:0] TMO = 8'(MEM_TMO);

    mem_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_d;
    logic [DATA_W-1:0] mar_q, mdr_q;
    logic              rd_ack;

    assign rd_ack = (state_q == MS_REQ) && mem_ack && !we_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = 1'b0;
        unique case (state_q)
            MS_IDLE: begin
                if (mem_rd && mem_wr) begin
                    err_d = 1'b1;
                end else if (mem_rd ^ mem_wr) begin
                    state_d = MS_REQ;
                    we_d    = mem_wr;
                    cnt_d   = '0;
                end
            end
            MS_REQ: begin
                err_d = mem_rd | mem_wr;
                if (mem_ack) begin
                    state_d = MS_DONE;
                end else if (cnt_q == TMO) begin
                    state_d = MS_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MS_DONE: begin
                err_d   = mem_rd | mem_wr;
                state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mem_err <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mem_err <= err_d;
            if (mar_ld && state_q == MS_IDLE) mar_q <= bus_d;
            // read data beats a bus load of MDR on the same edge
            if (rd_ack) mdr_q <= mem_rdata;
            else if (mdr_ld && state_q == MS_IDLE) mdr_q <= bus_d;
        end
    end

    assign mem_req   = (state_q == MS_REQ);
    assign mem_busy  = (state_q != MS_IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: register file, PC/IR/Y/Z/HI/LO, CON
// and the memory interface, all fed from one shared bus.
module param_bus_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int RA_LSB   = 23,
    parameter int C_W      = 19,
    parameter int MEM_TMO  = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [2:0]          gr_sel,
    input  logic                rin,
    input  logic                rout,
    input  logic                ba_out,
    input  logic [7:0]          out_sel,
    input  logic [8:0]          in_en,
    input  logic                inc_pc,
    input  logic                mem_rd,
    input  logic                mem_wr,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_busy,
    output logic                mem_err,
    input  logic [DATA_W-1:0]   inport_d,
    input  logic [2*DATA_W-1:0] alu_z,
    output logic [DATA_W-1:0]   bus_q,
    output logic [DATA_W-1:0]   y_q,
    output logic [DATA_W-1:0]   ir_q,
    output logic [DATA_W-1:0]   pc_q,
    output logic                con_q,
    output logic                bus_conflict
);

    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam int RB_LSB = RA_LSB - 4;
    localparam int RC_LSB = RA_LSB - 8;
    localparam int EXT_W  = DATA_W - C_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [2*DATA_W-1:0] z_q;
    logic [RIDX_W-1:0]   idx;
    logic                sel_ok;
    logic [DATA_W-1:0]   reg_val;
    logic [DATA_W-1:0]   c_ext;
    logic [8:0]          src;
    logic                multi_src;
    logic                con_d;
    con_cond_e           c2;

    // a gr_sel that is not one-hot disables register read and write
    always_comb begin
        idx    = '0;
        sel_ok = 1'b1;
        case (gr_sel)
            3'b001:  idx = ir_q[RA_LSB +: RIDX_W];
            3'b010:  idx = ir_q[RB_LSB +: RIDX_W];
            3'b100:  idx = ir_q[RC_LSB +: RIDX_W];
            default: sel_ok = 1'b0;
        endcase
    end

    assign reg_val   = (ba_out && idx == '0) ? '0 : regs[idx];
    assign c_ext     = {{EXT_W{ir_q[C_W-1]}}, ir_q[C_W-1:0]};
    assign src       = {out_sel, rout && sel_ok};
    assign multi_src = ($countones(src) > 1);

    always_comb begin
        bus_q = '0;
        if (src[0])                  bus_q = reg_val;
        else if (out_sel[OS_HI])     bus_q = hi_q;
        else if (out_sel[OS_LO])     bus_q = lo_q;
        else if (out_sel[OS_ZHI])    bus_q = z_q[2*DATA_W-1:DATA_W];
        else if (out_sel[OS_ZLO])    bus_q = z_q[DATA_W-1:0];
        else if (out_sel[OS_PC])     bus_q = pc_q;
        else if (out_sel[OS_MDR])    bus_q = mem_wdata;
        else if (out_sel[OS_INPORT]) bus_q = inport_d;
        else if (out_sel[OS_C])      bus_q = c_ext;
    end

    assign c2 = con_cond_e'(ir_q[RB_LSB +: 2]);

    always_comb begin
        con_d = 1'b0;
        unique case (c2)
            CC_ZERO:  con_d = (bus_q == '0);
            CC_NZERO: con_d = (bus_q != '0);
            CC_POS:   con_d = !bus_q[DATA_W-1];
            CC_NEG:   con_d = bus_q[DATA_W-1];
            default:  con_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            z_q          <= '0;
            y_q          <= '0;
            ir_q         <= '0;
            pc_q         <= '0;
            con_q        <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            if (rin && sel_ok) regs[idx] <= bus_q;
            if (in_en[IE_HI])  hi_q <= bus_q;
            if (in_en[IE_LO])  lo_q <= bus_q;
            if (in_en[IE_Z])   z_q  <= alu_z;
            if (in_en[IE_Y])   y_q  <= bus_q;
            if (in_en[IE_IR])  ir_q <= bus_q;
            if (in_en[IE_CON]) con_q <= con_d;
            if (in_en[IE_PC])  pc_q <= bus_q;
            else if (inc_pc)   pc_q <= pc_q + DATA_W'(1);
            bus_conflict <= multi_src;
        end
    end

    mem_if_fsm #(
        .DATA_W  (DATA_W),
        .MEM_TMO (MEM_TMO)
    ) u_mem (
        .clk       (clk),
        .clr       (clr),
        .mar_ld    (in_en[IE_MAR]),
        .mdr_ld    (in_en[IE_MDR]),
        .bus_d     (bus_q),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_busy  (mem_busy),
        .mem_err   (mem_err)
    );

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed scenarios then random control words, every cycle
// compared against a behavioural datapath model.
module tb_param_bus_datapath;

    localparam int W   = 32;
    localparam int NR  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          clr;
    logic [2:0]    gr_sel;
    logic          rin, rout, ba_out;
    logic [7:0]    out_sel;
    logic [8:0]    in_en;
    logic          inc_pc, mem_rd, mem_wr;
    logic          mem_req, mem_we, mem_ack;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic          mem_busy, mem_err;
    logic [W-1:0]  inport_d;
    logic [2*W-1:0] alu_z;
    logic [W-1:0]  bus_q, y_q, ir_q, pc_q;
    logic          con_q, bus_conflict;

    always #5 clk = ~clk;

    param_bus_datapath #(
        .DATA_W(W), .NUM_REGS(NR), .RA_LSB(23), .C_W(19), .MEM_TMO(TMO)
    ) dut (
        .clk(clk), .clr(clr), .gr_sel(gr_sel), .rin(rin), .rout(rout),
        .ba_out(ba_out), .out_sel(out_sel), .in_en(in_en), .inc_pc(inc_pc),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_err(mem_err),
        .inport_d(inport_d), .alu_z(alu_z), .bus_q(bus_q), .y_q(y_q),
        .ir_q(ir_q), .pc_q(pc_q), .con_q(con_q), .bus_conflict(bus_conflict)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // reference state; memory phase 0=idle 1=requesting 2=completing
    logic [W-1:0]   m_regs [NR];
    logic [W-1:0]   m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr;
    logic [2*W-1:0] m_z;
    bit             m_con, m_conf, m_err, m_we;
    int             m_phase, m_wait;
    logic [W-1:0]   bus_seen;

    function automatic int sel_idx();
        int f;
        case (gr_sel)
            3'b001:  f = 23;
            3'b010:  f = 19;
            3'b100:  f = 15;
            default: return -1;
        endcase
        return int'((m_ir >> f) & 32'hF);
    endfunction

    function automatic logic [W-1:0] ref_bus(output int n);
        logic [W-1:0] v [9];
        bit           e [9];
        int           r;
        logic [W-1:0] res;
        r = sel_idx();
        e[0] = rout && (r >= 0);
        v[0] = (r < 0 || (ba_out && r == 0)) ? '0 : m_regs[r];
        for (int k = 0; k < 8; k++) e[k+1] = out_sel[k];
        v[1] = m_hi;
        v[2] = m_lo;
        v[3] = m_z[63:32];
        v[4] = m_z[31:0];
        v[5] = m_pc;
        v[6] = m_mdr;
        v[7] = inport_d;
        v[8] = m_ir[18] ? (m_ir | 32'hFFF8_0000) : (m_ir & 32'h0007_FFFF);
        n = 0;
        res = '0;
        for (int k = 8; k >= 0; k--) begin
            if (e[k]) begin
                n++;
                res = v[k];
            end
        end
        return res;
    endfunction

    task automatic model_next(input logic [W-1:0] b, input int n);
        int r;
        bit busy, cv;
        if (clr) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            {m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr} = '0;
            m_z = '0;
            {m_con, m_conf, m_err, m_we} = '0;
            m_phase = 0;
            m_wait = 0;
            return;
        end
        r = sel_idx();
        busy = (m_phase != 0);
        case ((m_ir >> 19) & 32'h3)
            0:       cv = (b == 0);
            1:       cv = (b != 0);
            2:       cv = (b < 32'h8000_0000);
            default: cv = (b >= 32'h8000_0000);
        endcase
        if (rin && r >= 0) m_regs[r] = b;
        if (in_en[0]) m_hi = b;
        if (in_en[1]) m_lo = b;
        if (in_en[2]) m_z = alu_z;
        if (in_en[3]) m_pc = b;
        else if (inc_pc) m_pc = m_pc + 1;
        if (in_en[6]) m_ir = b;
        if (in_en[7]) m_y = b;
        if (in_en[8]) m_con = cv;
        if (m_phase == 1 && mem_ack && !m_we) m_mdr = mem_rdata;
        else if (in_en[4] && !busy) m_mdr = b;
        if (in_en[5] && !busy) m_mar = b;
        m_err = 0;
        if (m_phase == 0) begin
            if (mem_rd && mem_wr) m_err = 1;
            else if (mem_rd || mem_wr) begin
                m_phase = 1;
                m_we = mem_wr;
                m_wait = 0;
            end
        end else if (m_phase == 1) begin
            m_err = mem_rd || mem_wr;
            m_wait++;
            if (mem_ack) m_phase = 2;
            else if (m_wait > TMO) begin
                m_phase = 0;
                m_err = 1;
            end
        end else begin
            m_err = mem_rd || mem_wr;
            m_phase = 0;
        end
        m_conf = (n > 1);
    endtask

    task automatic check_state();
        chk("pc", pc_q, m_pc);
        chk("ir", ir_q, m_ir);
        chk("y", y_q, m_y);
        chk("con", con_q, m_con);
        chk("conflict", bus_conflict, m_conf);
        chk("mem_req", mem_req, m_phase == 1);
        chk("mem_busy", mem_busy, m_phase != 0);
        chk("mem_err", mem_err, m_err);
        chk("mem_addr", mem_addr, m_mar);
        chk("mem_wdata", mem_wdata, m_mdr);
        if (m_phase == 1) chk("mem_we", mem_we, m_we);
    endtask

    task automatic step();
        int n;
        logic [W-1:0] eb;
        #1;
        eb = ref_bus(n);
        bus_seen = bus_q;
        chk("bus", bus_q, eb);
        model_next(eb, n);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic ctl_zero();
        clr = 0; gr_sel = 0; rin = 0; rout = 0; ba_out = 0;
        out_sel = 0; in_en = 0; inc_pc = 0;
        mem_rd = 0; mem_wr = 0; mem_ack = 0;
    endtask

    task automatic load_in(input logic [W-1:0] v, input int bitn);
        ctl_zero();
        inport_d = v;
        out_sel = 8'h40;
        in_en = 9'(1 << bitn);
        step();
        ctl_zero();
    endtask

    initial begin
        int cnt, r;
        inport_d = '1;
        alu_z = '1;
        mem_rdata = '1;
        clr = 1; gr_sel = '1; rin = 1; rout = 1; ba_out = 1;
        out_sel = '1; in_en = '1; inc_pc = 1;
        mem_rd = 1; mem_wr = 1; mem_ack = 1;
        @(posedge clk);
        #1;
        model_next('0, 0);
        check_state();
        ctl_zero();
        #1;
        chk("rst_bus", bus_q, 0);
        chk("rst_pc", pc_q, 0);
        chk("rst_err", mem_err, 0);
        step();

        load_in(32'h0088_0005, 6);
        gr_sel = 3'b001; out_sel = 8'h80; rin = 1;
        step();
        ctl_zero();
        gr_sel = 3'b001; rout = 1;
        step();
        chk("r1_read", bus_seen, 5);
        load_in(32'h0000_0009, 6);
        gr_sel = 3'b001; out_sel = 8'h80; rin = 1;
        step();
        ctl_zero();
        gr_sel = 3'b001; rout = 1; ba_out = 1;
        step();
        chk("r0_base", bus_seen, 0);
        ba_out = 0;
        step();
        chk("r0_raw", bus_seen, 9);

        load_in(32'hA, 0);
        load_in(32'hB, 3);
        out_sel = 8'h11;
        step();
        chk("prio", bus_seen, 32'hA);
        chk("conflict_set", bus_conflict, 1);
        ctl_zero();
        step();
        chk("conflict_clr", bus_conflict, 0);

        load_in(32'h40, 5);
        mem_rd = 1;
        step();
        mem_rd = 0;
        chk("rd_addr", mem_addr, 32'h40);
        cnt = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            cnt++;
            mem_ack = (cnt == 3);
            mem_rdata = 32'hDEAD_BEEF;
            step();
        end
        mem_ack = 0;
        chk("rd_req_len", cnt, 3);
        out_sel = 8'h20;
        step();
        chk("mdr_read", bus_seen, 32'hDEAD_BEEF);
        ctl_zero();

        mem_wr = 1;
        step();
        mem_wr = 0;
        cnt = 0;
        for (int i = 0; i < 100 && mem_req; i++) begin
            cnt++;
            step();
        end
        chk("tmo_len", cnt, TMO + 1);
        chk("tmo_err", mem_err, 1);
        step();
        chk("err_pulse", mem_err, 0);

        mem_rd = 1;
        step();
        mem_rd = 0;
        step();
        clr = 1;
        step();
        clr = 0;
        chk("clr_req", mem_req, 0);
        mem_rd = 1; mem_wr = 1;
        step();
        ctl_zero();
        chk("both_err", mem_err, 1);
        chk("both_idle", mem_busy, 0);

        load_in(32'h0008_0000, 6);
        load_in(32'h7, 8);
        chk("con01", con_q, 1);
        load_in(32'h0018_0000, 6);
        load_in(32'h8000_0000, 8);
        chk("con11", con_q, 1);
        load_in(32'h0000_0000, 6);
        load_in(32'h7, 8);
        chk("con00", con_q, 0);
        load_in(32'hFFFF_FFFF, 3);
        inc_pc = 1;
        step();
        chk("pc_wrap", pc_q, 0);
        inport_d = 32'h55; out_sel = 8'h40; in_en = 9'h008;
        step();
        chk("pc_load_wins", pc_q, 32'h55);
        ctl_zero();

        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom % 200 == 0);
            r = $urandom % 10;
            if (r < 7) out_sel = 8'(1 << ($urandom % 8));
            else if (r < 8) out_sel = 0;
            else out_sel = 8'($urandom);
            rout = (out_sel == 0) ? 1'($urandom) : ($urandom % 8 == 0);
            gr_sel = ($urandom % 6 == 0) ? 3'($urandom) : 3'(1 << ($urandom % 3));
            ba_out = 1'($urandom);
            rin = ($urandom % 4 == 0);
            in_en = 9'($urandom) & 9'($urandom);
            inc_pc = 1'($urandom);
            mem_rd = ($urandom % 10 == 0);
            mem_wr = ($urandom % 10 == 0);
            mem_ack = (m_phase == 1) ? ($urandom % 4 == 0) : ($urandom % 32 == 0);
            mem_rdata = $urandom;
            inport_d = $urandom;
            alu_z = {$urandom, $urandom};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
